// File: rtl/mac_cpa.sv
// Pipelined carry-propagate resolver: sum + (carry << 1), one slice per stage.
// Optional MAC_CPA_SAT_EN clamps the result to all ones on carry-out.
module mac_cpa #(
  parameter int WIDTH    = 32,
  parameter int SEGMENTS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_cpa_sum,
  input  logic [WIDTH-1:0] i_cpa_carry,
  input  logic             i_cpa_valid,
  output logic             o_cpa_ready,
  output logic [WIDTH-1:0] o_cpa_result,
  output logic             o_cpa_cout,
  output logic             o_cpa_valid,
  input  logic             i_cpa_ready
);

  localparam int S = WIDTH / SEGMENTS;

  // Rank k holds an operand pair whose slices below k are already resolved in a_r.
  logic [WIDTH-1:0] a_r [SEGMENTS];
  logic [WIDTH-1:0] b_r [SEGMENTS];
  logic [SEGMENTS-1:0] c_r;
  logic [SEGMENTS-1:0] hi_r;
  logic [SEGMENTS:0]   v_r;
  logic [WIDTH-1:0]    res_r;
  logic                cout_r;

  logic [S:0]          slice_s [SEGMENTS];
  logic [WIDTH-1:0]    a_nxt_s [SEGMENTS];
  logic [SEGMENTS-1:0] c_nxt_s;
  logic [WIDTH-1:0]    fin_s;
  logic                fcout_s;
  logic                adv_s;

  assign adv_s        = !v_r[SEGMENTS] || i_cpa_ready;
  assign o_cpa_ready  = adv_s;
  assign o_cpa_valid  = v_r[SEGMENTS];
  assign o_cpa_result = res_r;
  assign o_cpa_cout   = cout_r;

  // Per-stage slice adders and the final carry/clamp selection.
  always_comb begin
    c_nxt_s = '0;
    for (int k = 0; k < SEGMENTS; k++) begin
      slice_s[k] = {1'b0, a_r[k][k*S +: S]} + {1'b0, b_r[k][k*S +: S]} + {{S{1'b0}}, c_r[k]};
      a_nxt_s[k] = a_r[k];
      a_nxt_s[k][k*S +: S] = slice_s[k][S-1:0];
      c_nxt_s[k] = slice_s[k][S];
    end
    // carry[WIDTH-1] has weight 2^WIDTH, so it only ever contributes to cout.
    fcout_s = c_nxt_s[SEGMENTS-1] | hi_r[SEGMENTS-1];
`ifdef MAC_CPA_SAT_EN
    if (fcout_s) begin
      fin_s = '1;
    end else begin
      fin_s = a_nxt_s[SEGMENTS-1];
    end
`else
    fin_s = a_nxt_s[SEGMENTS-1];
`endif
  end

  // Pipeline ranks and output register; everything freezes together on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SEGMENTS; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
      c_r    <= '0;
      hi_r   <= '0;
      v_r    <= '0;
      res_r  <= '0;
      cout_r <= 1'b0;
    end else if (adv_s) begin
      a_r[0]  <= i_cpa_sum;
      b_r[0]  <= {i_cpa_carry[WIDTH-2:0], 1'b0};
      c_r[0]  <= 1'b0;
      hi_r[0] <= i_cpa_carry[WIDTH-1];
      for (int k = 1; k < SEGMENTS; k++) begin
        a_r[k]  <= a_nxt_s[k-1];
        b_r[k]  <= b_r[k-1];
        c_r[k]  <= c_nxt_s[k-1];
        hi_r[k] <= hi_r[k-1];
      end
      v_r    <= {v_r[SEGMENTS-1:0], i_cpa_valid};
      res_r  <= fin_s;
      cout_r <= fcout_s;
    end
  end

endmodule

// File: tb/tb_mac_cpa.sv
// Scoreboard bench for mac_cpa (WIDTH=32, SEGMENTS=4); directed vectors.
module tb_mac_cpa;

`ifdef MAC_CPA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        cout;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpa_sum = '0;
  logic [31:0] cpa_carry = '0;
  logic        cpa_in_valid = 1'b0;
  logic        cpa_in_ready;
  logic [31:0] cpa_result;
  logic        cpa_cout;
  logic        cpa_out_valid;
  logic        cpa_out_ready = 1'b1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_emit = 0;
  exp_t sb[$];

  mac_cpa #(.WIDTH(32), .SEGMENTS(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_cpa_sum(cpa_sum),
    .i_cpa_carry(cpa_carry),
    .i_cpa_valid(cpa_in_valid),
    .o_cpa_ready(cpa_in_ready),
    .o_cpa_result(cpa_result),
    .o_cpa_cout(cpa_cout),
    .o_cpa_valid(cpa_out_valid),
    .i_cpa_ready(cpa_out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n && cpa_out_valid && cpa_out_ready) begin
      n_emit++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got=%0h want=none (cycle %0d)", cpa_result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {32'd0, cpa_result}, {32'd0, e.res});
        chk("cout", {63'd0, cpa_cout}, {63'd0, e.cout});
        if (e.cyc >= 0) chk("emit_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drive one input until accepted; timed items also check 4-edge latency.
  task automatic send(input logic [31:0] s, input logic [31:0] c,
                      input logic [31:0] r, input logic co, input bit timed);
    bit done = 1'b0;
    cpa_sum = s;
    cpa_carry = c;
    cpa_in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cpa_in_ready) begin
        sb.push_back('{res: r, cout: co, cyc: (timed ? cyc + 5 : -1)});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=not_accepted want=accepted");
    end
    cpa_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    idle(2);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n0;
    #3;
    chk("rst_valid", {63'd0, cpa_out_valid}, 64'd0);
    chk("rst_result", {32'd0, cpa_result}, 64'd0);
    chk("rst_cout", {63'd0, cpa_cout}, 64'd0);
    chk("rst_ready", {63'd0, cpa_in_ready}, 64'd1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic resolve and a few plain patterns.
    send(32'h0000_00F0, 32'h0000_0008, 32'h0000_0100, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1111_1111, 32'h3456_789A, 1'b0, 1'b1);
    send(32'h00FF_00FF, 32'h0000_0080, 32'h00FF_01FF, 1'b0, 1'b1);
    drain();

    // Cross-slice ripple, back to back.
    send(32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send(32'hFFFF_FFFE, 32'h0000_0001, SAT ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1, 1'b1);
    // Top carry bit alone, and an overflow through the top slice.
    send(32'h0000_0000, 32'h8000_0000, SAT ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h4000_0000, SAT ? 32'hFFFF_FFFF : 32'h0000_0000, 1'b1, 1'b1);
    drain();

    // Bubbles: inputs on relative cycles 0, 2, 5.
    send(32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 1'b0, 1'b1);
    idle(1);
    send(32'h0000_0022, 32'h0000_0001, 32'h0000_0024, 1'b0, 1'b1);
    idle(2);
    send(32'h0000_0033, 32'h0000_0002, 32'h0000_0037, 1'b0, 1'b1);
    drain();

    // Backpressure: 6 items, downstream stalls 3 cycles on the first result.
    fork
      begin
        for (int i = 1; i <= 6; i++) send(32'(i), 32'h0, 32'(i), 1'b0, 1'b0);
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk);
          #1;
          if (cpa_out_valid) seen = 1'b1;
        end
        chk("bp_first_seen", {63'd0, seen}, 64'd1);
        cpa_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", {63'd0, cpa_out_valid}, 64'd1);
          chk("stall_result", {32'd0, cpa_result}, 64'd1);
          chk("stall_ready", {63'd0, cpa_in_ready}, 64'd0);
          @(posedge clk);
          #1;
        end
        cpa_out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three items in flight.
    send(32'h0000_0A00, 32'h0000_0000, 32'h0000_0A00, 1'b0, 1'b1);
    send(32'h0000_0B00, 32'h0000_0000, 32'h0000_0B00, 1'b0, 1'b1);
    send(32'h0000_0C00, 32'h0000_0000, 32'h0000_0C00, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, cpa_out_valid}, 64'd0);
    chk("midrst_result", {32'd0, cpa_result}, 64'd0);
    chk("midrst_cout", {63'd0, cpa_cout}, 64'd0);
    chk("midrst_ready", {63'd0, cpa_in_ready}, 64'd1);
    sb.delete();
    n0 = n_emit;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(12);
    chk("no_stale_after_reset", 64'(n_emit - n0), 64'd0);

    send(32'h1234_5678, 32'h1111_1111, 32'h3456_789A, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_cpa.md
# mac_cpa

Pipelined carry-propagate resolver that converts the redundant carry-save pair from the MAC's 3:2 compressor stage into a single binary result. It computes `sum + (carry << 1)` over `SEGMENTS` register stages, one `WIDTH/SEGMENTS`-bit slice per stage, with the inter-slice carry forwarded through the pipeline. It sits between the carry-save accumulator and the MAC output port. Valid/ready handshakes are provided on both sides.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be divisible by `SEGMENTS`.
- `SEGMENTS`, default 4: number of pipeline stages, i.e. adder slices; legal range 1..`WIDTH`.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_cpa_sum` input `WIDTH`: carry-save sum vector.
- `i_cpa_carry` input `WIDTH`: carry-save carry vector, weight 2^(i+1) per bit i.
- `i_cpa_valid` input 1: input pair valid.
- `o_cpa_ready` output 1: block accepts input this cycle.
- `o_cpa_result` output `WIDTH`: resolved binary result.
- `o_cpa_cout` output 1: set when the true total is ≥ 2^`WIDTH`.
- `o_cpa_valid` output 1: result valid.
- `i_cpa_ready` input 1: downstream accepts result.

## Operation
- Operand B = `{i_cpa_carry[WIDTH-2:0], 1'b0}`. Bit `i_cpa_carry[WIDTH-1]` (weight 2^WIDTH) is captured at input and carried alongside the data as `hi_c`.
- Slice width S = `WIDTH/SEGMENTS`.
- Stage k (0-based) adds bits `[k*S +: S]` of the sum vector and B, plus carry-in `c_k`.
  - `c_0` = 0.
  - `c_k` = stage k-1 carry-out, registered.
- Slices not yet processed travel in the stage registers unchanged. Resolved slices are held until the last stage.
- Final `o_cpa_cout` = last-stage carry-out OR `hi_c`.
- Result is `(sum + (carry<<1)) mod 2^WIDTH`. Unsigned interpretation throughout.
- A per-stage valid bit travels with each slot. Bubbles occupy slots and are not compressed.
- Global advance: `adv = !o_cpa_valid || i_cpa_ready`.
  - All stage registers load only when `adv` is high.
  - `o_cpa_ready = adv`.
  - An input is accepted when `i_cpa_valid && o_cpa_ready`.
- No internal state machine beyond the valid shift chain.

## Timing
- Latency: an input accepted at edge N appears on the outputs after edge N+`SEGMENTS`, provided no stall occurs.
- Throughput: 1 result per cycle when `i_cpa_ready` is held high.
- Outputs are registered.
- `o_cpa_ready` is combinational from `i_cpa_ready` and `o_cpa_valid` only. It never depends on `i_cpa_valid`.
- Stall (`o_cpa_valid && !i_cpa_ready`):
  - All stages freeze.
  - `o_cpa_result`, `o_cpa_cout` and `o_cpa_valid` hold stable.
  - `o_cpa_ready` = 0.
- Accept and emit in the same cycle is legal. The pipeline shifts by one and occupancy is unchanged.
- `i_cpa_valid` low while advancing inserts a bubble.
- Reset, asserted at any time, including mid-stream or mid-stall:
  - All valid bits clear immediately. In-flight data is discarded.
  - `o_cpa_valid`=0, `o_cpa_result`=0, `o_cpa_cout`=0, `o_cpa_ready`=1.
- After deassertion, the first accept may occur on the next rising edge.
- `SEGMENTS`=1: a single registered full-width add, latency 1.

## Configuration
- Macro: `MAC_CPA_SAT_EN`.
- Defined: when the final cout is 1, `o_cpa_result` is forced to all ones and `o_cpa_cout` still reports 1. The clamp is applied in the last stage and adds no latency.
- Undefined: `o_cpa_result` is the wrapped modulo-2^`WIDTH` value.

## Test plan
Defaults unless stated: `WIDTH`=32, `SEGMENTS`=4, `i_cpa_ready`=1.
- Basic resolve: sum=0x0000_00F0, carry=0x0000_0008 accepted at cycle 0 → cycle 4 shows result=0x0000_0100, cout=0, valid=1 for one cycle.
- Cross-slice ripple: sum=0xFFFF_FFFF, carry=0x0000_0000 followed by sum=0xFFFF_FFFE, carry=0x0000_0001 back-to-back → results 0xFFFF_FFFF/cout=0, then 0x0000_0000/cout=1, on consecutive cycles.
- Top carry bit: sum=0, carry=0x8000_0000 → result=0x0000_0000, cout=1. With `MAC_CPA_SAT_EN` defined → result=0xFFFF_FFFF, cout=1.
- Backpressure:
  - Stream 6 inputs with values 1..6 in the sum vector and carry=0.
  - Drop `i_cpa_ready` for 3 cycles after the first result.
  - Required: output holds at 1 and `o_cpa_ready`=0 for those cycles; all 6 results emerge in order with none lost or duplicated.
- Bubbles: inputs on cycles 0, 2 and 5 → `o_cpa_valid` high only on cycles 4, 6 and 9.
- Reset mid-stream: assert `i_rst_n`=0 asynchronously with 3 items in flight → outputs zero and valid=0 immediately; after release, no stale result ever appears.
